// File: rtl/canxl_pkg.sv
// -----------------------------------------------------------------------------
// canxl_pkg
// Shared CAN XL definitions for the preface CRC (PCRC) generator and checker.
//   PCRC_W    : PCRC width (13 bits)
//   PCRC_POLY : PCRC generator polynomial, implicit x^13 term
//   pcrc_chk_state_t : RX PCRC checker states
// -----------------------------------------------------------------------------
package canxl_pkg;

  localparam int unsigned PCRC_W = 13;
  localparam logic [PCRC_W-1:0] PCRC_POLY = 13'h19E7;

  typedef enum logic [1:0] {
    IDLE,
    PREFACE,
    FIELD,
    CHECK
  } pcrc_chk_state_t;

endpackage

// File: rtl/canxl_pcrc_lfsr.sv
// -----------------------------------------------------------------------------
// canxl_pcrc_lfsr
// Single-step serial PCRC register, shared by the TX generator and RX checker.
// Ports:
//   clk    : clock
//   g_rst  : asynchronous active-high reset
//   i_clr  : synchronous clear to zero (wins over i_en)
//   i_en   : advance the CRC by one bit
//   i_bit  : data bit to fold in
//   o_crc  : current CRC value
// -----------------------------------------------------------------------------
module canxl_pcrc_lfsr
  import canxl_pkg::*;
#(
  parameter int unsigned      W    = PCRC_W,
  parameter logic [W-1:0]     POLY = PCRC_POLY
) (
  input  logic         clk,
  input  logic         g_rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_bit,
  output logic [W-1:0] o_crc
);

  logic [W-1:0] r_crc;
  logic         w_fb;

  // Feedback: incoming bit against the outgoing MSB.
  assign w_fb = i_bit ^ r_crc[W-1];

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/canxl_pcrc_check.sv
// -----------------------------------------------------------------------------
// canxl_pcrc_check
// Receive-side CAN XL preface CRC checker. Accumulates the PCRC over destuffed
// preface bits, captures the 13-bit received PCRC field (MSB first, stuff bits
// skipped), compares them and issues a one-cycle verdict.
//
// Optional feature (macro CANXL_PCRC_ERRCNT_EN): adds o_pcrc_err_cnt, a
// saturating count of error verdicts cleared only by g_rst.
//
// Ports:
//   clk, g_rst        : clock, asynchronous active-high reset
//   i_rx_bit          : sampled bus bit
//   i_bit_valid       : one-cycle strobe, i_rx_bit is new
//   i_stuff_bit       : qualifies i_bit_valid as a stuff bit (ignored)
//   i_sof             : frame start, restarts the checker
//   i_preface_en      : bit belongs to the PCRC-protected preface
//   i_pcrc_field_en   : bit belongs to the PCRC field (wins over preface)
//   i_abort           : frame ended, clears the checker
//   o_pcrc_calc       : running/final computed CRC
//   o_pcrc_rcv        : captured received field
//   o_pcrc_done       : verdict strobe
//   o_pcrc_ok         : with done, match
//   o_pcrc_err        : with done, mismatch or truncated field
//   o_pcrc_trunc      : with err, field ended before 13 bits
//   o_busy            : checker not idle
//   o_pcrc_err_cnt    : (optional) saturating error-verdict counter
// -----------------------------------------------------------------------------
module canxl_pcrc_check
  import canxl_pkg::*;
#(
  parameter int unsigned          CRC_W = PCRC_W,
  parameter logic [CRC_W-1:0]     POLY  = PCRC_POLY
) (
  input  logic             clk,
  input  logic             g_rst,
  input  logic             i_rx_bit,
  input  logic             i_bit_valid,
  input  logic             i_stuff_bit,
  input  logic             i_sof,
  input  logic             i_preface_en,
  input  logic             i_pcrc_field_en,
  input  logic             i_abort,
  output logic [CRC_W-1:0] o_pcrc_calc,
  output logic [CRC_W-1:0] o_pcrc_rcv,
  output logic             o_pcrc_done,
  output logic             o_pcrc_ok,
  output logic             o_pcrc_err,
  output logic             o_pcrc_trunc,
  output logic             o_busy
`ifdef CANXL_PCRC_ERRCNT_EN
  ,
  output logic [7:0]       o_pcrc_err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(CRC_W + 1);

  pcrc_chk_state_t  r_state;
  logic [CRC_W-1:0] r_rcv;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trunc;

  logic             w_ebit;
  logic             w_clr;
  logic             w_crc_en;
  logic [CRC_W-1:0] w_calc;
  logic             w_verdict;
  logic             w_match;

  // Stuff bits carry no data: they never touch CRC, capture or state.
  assign w_ebit = i_bit_valid & ~i_stuff_bit;
  assign w_clr  = i_abort | i_sof;

  // Only preface bits in PREFACE feed the CRC; a field bit takes precedence.
  assign w_crc_en = ~w_clr & (r_state == PREFACE) & w_ebit & i_preface_en &
                    ~i_pcrc_field_en;

  canxl_pcrc_lfsr #(
    .W    (CRC_W),
    .POLY (POLY)
  ) u_lfsr (
    .clk   (clk),
    .g_rst (g_rst),
    .i_clr (w_clr),
    .i_en  (w_crc_en),
    .i_bit (i_rx_bit),
    .o_crc (w_calc)
  );

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_state <= IDLE;
      r_rcv   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (i_abort) begin
      r_state <= IDLE;
      r_rcv   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else if (i_sof) begin
      r_state <= PREFACE;
      r_rcv   <= '0;
      r_cnt   <= '0;
      r_trunc <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state <= IDLE;
        end
        PREFACE: begin
          // First field bit is captured on the transition itself.
          if (w_ebit && i_pcrc_field_en) begin
            r_rcv   <= {r_rcv[CRC_W-2:0], i_rx_bit};
            r_cnt   <= CNT_W'(1);
            r_trunc <= 1'b0;
            r_state <= FIELD;
          end
        end
        FIELD: begin
          if (w_ebit) begin
            if (i_pcrc_field_en) begin
              r_rcv <= {r_rcv[CRC_W-2:0], i_rx_bit};
              r_cnt <= r_cnt + CNT_W'(1);
              if (r_cnt == CNT_W'(CRC_W - 1)) begin
                r_state <= CHECK;
              end
            end else begin
              // Field ended early.
              r_trunc <= 1'b1;
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // The verdict is qualified in the CHECK cycle itself so that a same-cycle
  // sof or abort can suppress it.
  assign w_verdict = (r_state == CHECK) & ~i_sof & ~i_abort;
  assign w_match   = ~r_trunc & (r_rcv == w_calc);

  assign o_pcrc_done  = w_verdict;
  assign o_pcrc_ok    = w_verdict & w_match;
  assign o_pcrc_err   = w_verdict & ~w_match;
  assign o_pcrc_trunc = w_verdict & r_trunc;
  assign o_pcrc_calc  = w_calc;
  assign o_pcrc_rcv   = r_rcv;
  assign o_busy       = (r_state != IDLE);

`ifdef CANXL_PCRC_ERRCNT_EN
  logic [7:0] r_err_cnt;

  // Survives sof/abort; only g_rst clears it.
  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      r_err_cnt <= '0;
    end else if (o_pcrc_err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign o_pcrc_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_canxl_pcrc_check.sv
// -----------------------------------------------------------------------------
// tb_canxl_pcrc_check
// Directed scoreboard bench for canxl_pcrc_check. Stimulus tasks push the
// expected verdict (with its cycle) into a queue; a negedge monitor pops and
// compares whenever the DUT strobes a verdict.
// -----------------------------------------------------------------------------
module tb_canxl_pcrc_check;

  logic        clk = 1'b0;
  logic        g_rst;
  logic        rx_bit, bit_valid, stuff_bit, sof, preface_en, pcrc_field_en, abort_i;
  logic [12:0] pcrc_calc, pcrc_rcv;
  logic        pcrc_done, pcrc_ok, pcrc_err, pcrc_trunc, busy;
`ifdef CANXL_PCRC_ERRCNT_EN
  logic [7:0]  pcrc_err_cnt;
`endif

  canxl_pcrc_check u_dut (
    .clk             (clk),
    .g_rst           (g_rst),
    .i_rx_bit        (rx_bit),
    .i_bit_valid     (bit_valid),
    .i_stuff_bit     (stuff_bit),
    .i_sof           (sof),
    .i_preface_en    (preface_en),
    .i_pcrc_field_en (pcrc_field_en),
    .i_abort         (abort_i),
    .o_pcrc_calc     (pcrc_calc),
    .o_pcrc_rcv      (pcrc_rcv),
    .o_pcrc_done     (pcrc_done),
    .o_pcrc_ok       (pcrc_ok),
    .o_pcrc_err      (pcrc_err),
    .o_pcrc_trunc    (pcrc_trunc),
    .o_busy          (busy)
`ifdef CANXL_PCRC_ERRCNT_EN
    ,
    .o_pcrc_err_cnt  (pcrc_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        ok;
    logic        err;
    logic        trunc;
    logic [12:0] calc;
    logic [12:0] rcv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: compare each verdict against the scoreboard head.
  always @(negedge clk) begin
    if (!g_rst) begin
      if (pcrc_done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_verdict: ok=%b err=%b trunc=%b at cyc %0d",
                   pcrc_ok, pcrc_err, pcrc_trunc, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.cyc != cyc || pcrc_ok !== e.ok || pcrc_err !== e.err ||
              pcrc_trunc !== e.trunc || pcrc_calc !== e.calc || pcrc_rcv !== e.rcv) begin
            errors++;
            $display("FAIL verdict: got cyc=%0d ok=%b err=%b trunc=%b calc=%h rcv=%h expected cyc=%0d ok=%b err=%b trunc=%b calc=%h rcv=%h",
                     cyc, pcrc_ok, pcrc_err, pcrc_trunc, pcrc_calc, pcrc_rcv,
                     e.cyc, e.ok, e.err, e.trunc, e.calc, e.rcv);
          end
        end
      end else begin
        if (pcrc_ok || pcrc_err || pcrc_trunc) begin
          checks++;
          errors++;
          $display("FAIL strobe_without_done: ok=%b err=%b trunc=%b expected 0 0 0",
                   pcrc_ok, pcrc_err, pcrc_trunc);
        end
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_verdict: got none expected at cyc %0d", e.cyc);
        end
      end
    end
  end

  task automatic clear_inputs();
    rx_bit = 1'b0; bit_valid = 1'b0; stuff_bit = 1'b0; sof = 1'b0;
    preface_en = 1'b0; pcrc_field_en = 1'b0; abort_i = 1'b0;
  endtask

  task automatic do_sof();
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
  endtask

  task automatic do_abort();
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
  endtask

  task automatic send(input logic b, input logic pre, input logic fld, input logic stf);
    rx_bit = b; bit_valid = 1'b1; stuff_bit = stf; preface_en = pre; pcrc_field_en = fld;
    @(posedge clk); #1;
    bit_valid = 1'b0; stuff_bit = 1'b0; preface_en = 1'b0; pcrc_field_en = 1'b0;
  endtask

  task automatic send_field(input logic [12:0] v, input int nbits);
    for (int i = 0; i < nbits; i++) send(v[12-i], 1'b0, 1'b1, 1'b0);
  endtask

  // Called right after the consuming edge; the verdict is due this cycle.
  task automatic expect_v(input logic ok, input logic err, input logic trunc,
                          input logic [12:0] calc, input logic [12:0] rcv);
    exp_t e;
    e.cyc = cyc; e.ok = ok; e.err = err; e.trunc = trunc; e.calc = calc; e.rcv = rcv;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] v;
    clear_inputs();
    g_rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_calc", pcrc_calc, 0);
    chk("reset_rcv", pcrc_rcv, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", pcrc_done, 0);
    @(posedge clk); #1;
    g_rst = 1'b0;

    // All-zero frame
    do_sof();
    @(negedge clk);
    chk("sof_busy", busy, 1);
    @(posedge clk); #1;
    repeat (8) send(1'b0, 1'b1, 1'b0, 1'b0);
    send_field(13'h0000, 13);
    expect_v(1, 0, 0, 13'h0000, 13'h0000);
    drain();

    // Single-one preface: CRC equals the polynomial
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send_field(13'h19E7, 13);
    expect_v(1, 0, 0, 13'h19E7, 13'h19E7);
    drain();
    repeat (3) @(negedge clk);
    chk("hold_calc", pcrc_calc, 13'h19E7);
    chk("hold_rcv", pcrc_rcv, 13'h19E7);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;

    // Preface "1,0" -> 0x0A29
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    send_field(13'h0A29, 13);
    expect_v(1, 0, 0, 13'h0A29, 13'h0A29);
    drain();

    // Same, last field bit flipped
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    send_field(13'h0A28, 13);
    expect_v(0, 1, 0, 13'h0A29, 13'h0A28);
    drain();

    // Stuff bits in preface and field; first field bit also has preface_en
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b0);
    v = 13'h0A29;
    send(v[12], 1'b1, 1'b1, 1'b0);
    for (int i = 11; i >= 6; i--) send(v[i], 1'b0, 1'b1, 1'b0);
    send(~v[5], 1'b0, 1'b1, 1'b1);
    for (int i = 5; i >= 0; i--) send(v[i], 1'b0, 1'b1, 1'b0);
    expect_v(1, 0, 0, 13'h0A29, 13'h0A29);
    drain();

    // Truncated field: 7 bits then a non-field bit
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send_field(13'h1555, 7);
    send(1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(0, 1, 1, 13'h19E7, 13'h0055);
    drain();

    // Abort mid-field: no verdict, cleared
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send_field(13'h1FFF, 5);
    do_abort();
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_calc", pcrc_calc, 0);
    chk("abort_rcv", pcrc_rcv, 0);
    repeat (5) @(posedge clk);
    #1;

    // sof in CHECK suppresses the verdict and restarts
    do_sof();
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send_field(13'h19E7, 13);
    do_sof();
    @(negedge clk);
    chk("sof_in_check_busy", busy, 1);
    chk("sof_in_check_calc", pcrc_calc, 0);
    chk("sof_in_check_rcv", pcrc_rcv, 0);
    @(posedge clk); #1;
    do_abort();
    repeat (3) @(posedge clk);
    #1;

`ifdef CANXL_PCRC_ERRCNT_EN
    chk("errcnt_two", pcrc_err_cnt, 8'd2);
    for (int f = 0; f < 256; f++) begin
      do_sof();
      send_field(13'h0001, 13);
      expect_v(0, 1, 0, 13'h0000, 13'h0001);
      drain();
    end
    chk("errcnt_saturated", pcrc_err_cnt, 8'hFF);
    g_rst = 1'b1;
    @(posedge clk); #1;
    g_rst = 1'b0;
    @(negedge clk);
    chk("errcnt_reset", pcrc_err_cnt, 8'h00);
`endif

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
